stack_ctl: RTL

//   Self-managing LIFO data/return stack for the core: owns its stack pointer and

---
 rtl/stack_ctl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stack_ctl.sv
// rtl/stack_ctl.sv - self-managing LIFO stack with push/pop/replace and top/next/peek reads
// Build option: define STACK_GUARD_EN for blocked over/underflow with sticky ovf/unf flags.
module stack_ctl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [DEPTH-1:0] pa,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] pd,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    input  logic             clr_err,
    output logic             ovf,
    output logic             unf
);

    localparam int ENTRIES = 1 << DEPTH;
    localparam logic [DEPTH:0]   CNT_MAX = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0]   CNT_ONE = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] PTR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] PTR_TWO = PTR_ONE + PTR_ONE;

    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    logic [WIDTH-1:0] store [ENTRIES];
    logic [DEPTH-1:0] sp;
    logic [DEPTH-1:0] top_idx;
    logic [DEPTH-1:0] next_idx;
    logic [DEPTH-1:0] peek_idx;

    logic do_push;
    logic do_pop;
    logic do_replace;
    logic push_ok;
    logic pop_ok;
    logic replace_ok;

    // All offsets wrap modulo 2**DEPTH by virtue of the DEPTH-bit width.
    assign top_idx  = sp - PTR_ONE;
    assign next_idx = sp - PTR_TWO;
    assign peek_idx = sp - PTR_ONE - pa;

    assign tos   = store[top_idx];
    assign nos   = store[next_idx];
    assign pd    = store[peek_idx];
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    assign do_push    = (op == OP_PUSH);
    assign do_pop     = (op == OP_POP);
    assign do_replace = (op == OP_REPLACE);

`ifdef STACK_GUARD_EN
    logic ovf_set;
    logic unf_set;

    assign push_ok    = do_push && !full;
    assign pop_ok     = do_pop && !empty;
    assign replace_ok = do_replace && !empty;
    assign ovf_set    = do_push && full;
    assign unf_set    = (do_pop || do_replace) && empty;

    // A fresh error in the same cycle as clr_err takes priority over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
            if (unf_set)
                unf <= 1'b1;
            else if (clr_err)
                unf <= 1'b0;
        end
    end
`else
    logic unused_clr_err;

    assign push_ok        = do_push;
    assign pop_ok         = do_pop;
    assign replace_ok     = do_replace;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
    assign unused_clr_err = clr_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                sp <= sp + PTR_ONE;
                if (count != CNT_MAX)
                    count <= count + CNT_ONE;
            end else if (pop_ok) begin
                sp <= sp - PTR_ONE;
                if (count != '0)
                    count <= count - CNT_ONE;
            end
        end
    end

    // Storage has no reset; a reset cycle simply suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_ok)
                store[sp] <= din;
            else if (replace_ok)
                store[top_idx] <= din;
        end
    end

endmodule
